// File: rtl/q2_i2c_target.sv
// q2_i2c_target: I2C target modelling an 8-bit port expander.
// Bus lines are oversampled on clk. The target matches a 7-bit address,
// latches written bytes onto port_out, and returns port_in on reads.
// SDA is open-drain: sda_pull=1 pulls the line low, 0 releases it.
//
// Handshake: none. wr_strobe is a one-clk pulse that is high in the
// same cycle that port_out first shows the new byte.
//
// Debug: dbg_state_o shows the FSM state using the state_e encoding.
module q2_i2c_target #(
   parameter logic [6:0] ADDR        = 7'h27,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_pull,
   input  logic [7:0] port_in,
   output logic [7:0] port_out,
   output logic       wr_strobe,
   output logic       busy,
   output logic [2:0] dbg_state_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR_S    = 3'd1,
      ADDR_ACK  = 3'd2,
      WRITE     = 3'd3,
      WRITE_ACK = 3'd4,
      READ      = 3'd5,
      READ_ACK  = 3'd6,
      IGNORE    = 3'd7
   } state_e;

   // Synchronizers and history flops. They reset to 1 (the idle bus level),
   // so no false edge is seen when reset is released.
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_d_q, sda_d_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       bit9_q, bit9_d;   // 9th-bit flag: ACK driven / master ACK seen
   logic [7:0] shift_q, shift_d;
   logic       rw_q, rw_d;
   logic       pull_q, pull_d;
   logic [7:0] port_q, port_d;
   logic       strobe_q, strobe_d;
   logic       busy_q, busy_d;

   // Shift both bus lines through the synchronizer chains and history flops.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_d_q    <= 1'b1;
         sda_d_q    <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_d_q    <= scl_sync_q[SYNC_STAGES-1];
         sda_d_q    <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d_q;
   assign scl_fall  = ~scl_s & scl_d_q;
   assign start_det = scl_s & ~sda_s & sda_d_q;
   assign stop_det  = scl_s & sda_s & ~sda_d_q;

   // State register and all protocol registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         bit9_q   <= 1'b0;
         shift_q  <= 8'h00;
         rw_q     <= 1'b0;
         pull_q   <= 1'b0;
         port_q   <= 8'h00;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit9_q   <= bit9_d;
         shift_q  <= shift_d;
         rw_q     <= rw_d;
         pull_q   <= pull_d;
         port_q   <= port_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state logic. START/STOP are checked first, so they win over any
   // SCL edge that is detected in the same clk.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit9_d   = bit9_q;
      shift_d  = shift_q;
      rw_d     = rw_q;
      pull_d   = pull_q;
      port_d   = port_q;
      strobe_d = 1'b0;
      busy_d   = busy_q;

      if (state_q != IDLE && stop_det) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         pull_d  = 1'b0;
         cnt_d   = 3'd0;
         bit9_d  = 1'b0;
      end else if (start_det) begin
         state_d = ADDR_S;
         busy_d  = 1'b1;
         pull_d  = 1'b0;
         cnt_d   = 3'd0;
         bit9_d  = 1'b0;
         shift_d = 8'h00;
      end else begin
         case (state_q)
            ADDR_S: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  if (cnt_q == 3'd7) begin
                     cnt_d   = 3'd0;
                     bit9_d  = 1'b0;
                     rw_d    = sda_s;
                     state_d = (shift_d[7:1] == ADDR) ? ADDR_ACK : IGNORE;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            ADDR_ACK, WRITE_ACK: begin
               if (scl_fall) begin
                  if (!bit9_q) begin
                     pull_d = 1'b1;
                     bit9_d = 1'b1;
                  end else begin
                     bit9_d = 1'b0;
                     cnt_d  = 3'd0;
                     if (state_q == ADDR_ACK && rw_q) begin
                        shift_d = port_in;
                        pull_d  = ~port_in[7];
                        state_d = READ;
                     end else begin
                        pull_d  = 1'b0;
                        state_d = WRITE;
                     end
                  end
               end
            end
            WRITE: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  if (cnt_q == 3'd7) begin
                     port_d   = shift_d;
                     strobe_d = 1'b1;
                     cnt_d    = 3'd0;
                     bit9_d   = 1'b0;
                     state_d  = WRITE_ACK;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            READ: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     pull_d  = 1'b0;
                     cnt_d   = 3'd0;
                     bit9_d  = 1'b0;
                     state_d = READ_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     pull_d  = ~shift_d[7];
                     cnt_d   = cnt_q + 3'd1;
                  end
               end
            end
            READ_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     bit9_d = 1'b1;
                  end else begin
                     bit9_d  = 1'b0;
                     state_d = IGNORE;
                  end
               end else if (scl_fall && bit9_q) begin
                  bit9_d  = 1'b0;
                  cnt_d   = 3'd0;
                  shift_d = port_in;
                  pull_d  = ~port_in[7];
                  state_d = READ;
               end
            end
            IGNORE: begin
               pull_d = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign sda_pull    = pull_q;
   assign port_out    = port_q;
   assign wr_strobe   = strobe_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_q2_i2c_target.sv
// Directed bench for q2_i2c_target: a bit-banged I2C master on a wired-AND SDA.
module tb_q2_i2c_target;

   logic       clk;
   logic       nrst;
   logic       scl_m;
   logic       sda_m;
   logic       sda_bus;
   logic       sda_pull;
   logic [7:0] port_in;
   logic [7:0] port_out;
   logic       wr_strobe;
   logic       busy;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   int strobe_cnt = 0;
   int pull_cnt   = 0;
   logic [7:0] exp_q[$];

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_IGNORE = 3'd7;

   // The bus is open-drain: it is low if the master or the target pulls it.
   assign sda_bus = sda_m & ~sda_pull;

   q2_i2c_target #(.ADDR(7'h27), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .scl_in      (scl_m),
      .sda_in      (sda_bus),
      .sda_pull    (sda_pull),
      .port_in     (port_in),
      .port_out    (port_out),
      .wr_strobe   (wr_strobe),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: each wr_strobe pops the next expected port_out byte.
   always @(negedge clk) begin
      if (nrst && sda_pull) pull_cnt++;
      if (nrst && wr_strobe) begin
         strobe_cnt++;
         check("strobe_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("port_out_on_strobe", port_out, exp_q.pop_front());
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      if (scl_m == 1'b0) begin
         sda_m = 1'b1; wait_clk(8);
         scl_m = 1'b1; wait_clk(8);
      end
      sda_m = 1'b0; wait_clk(8);
      scl_m = 1'b0; wait_clk(8);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(8);
      scl_m = 1'b1; wait_clk(8);
      sda_m = 1'b1; wait_clk(8);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    wait_clk(8);
      scl_m = 1'b1; wait_clk(8);
      scl_m = 1'b0; wait_clk(8);
   endtask

   // Send a byte, then clock the ACK slot and check the target's response.
   task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; wait_clk(8);
      scl_m = 1'b1; wait_clk(4);
      check(tag, sda_pull, exp_ack);
      wait_clk(4);
      scl_m = 1'b0; wait_clk(8);
   endtask

   // Clock in a byte from the target, then ACK (m_ack=1) or NACK it.
   task automatic read_byte(output logic [7:0] b, input logic m_ack);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sda_m = 1'b1; wait_clk(8);
         scl_m = 1'b1; wait_clk(4);
         b = {b[6:0], sda_bus};
         wait_clk(4);
         scl_m = 1'b0; wait_clk(8);
      end
      sda_m = ~m_ack; wait_clk(8);
      scl_m = 1'b1;   wait_clk(8);
      scl_m = 1'b0;   wait_clk(8);
      sda_m = 1'b1;
   endtask

   initial begin
      logic [7:0] rb;
      int s0, p0;

      // Power-on reset.
      nrst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; port_in = 8'h00;
      wait_clk(5);
      check("rst_pull", sda_pull, 0);
      check("rst_port_out", port_out, 8'h00);
      check("rst_strobe", wr_strobe, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, ST_IDLE);
      nrst = 1'b1;
      wait_clk(5);

      // Single write: address 0x27/W, data A5.
      s0 = strobe_cnt;
      exp_q.push_back(8'hA5);
      i2c_start();
      check("wr_busy_after_start", busy, 1);
      write_byte(8'h4E, 1'b1, "wr_addr_ack");
      write_byte(8'hA5, 1'b1, "wr_data_ack");
      check("wr_port_out", port_out, 8'hA5);
      i2c_stop();
      check("wr_busy_after_stop", busy, 0);
      check("wr_strobe_count", strobe_cnt - s0, 1);

      // Address mismatch: target stays silent and port_out holds.
      s0 = strobe_cnt; p0 = pull_cnt;
      i2c_start();
      check("nm_busy_after_start", busy, 1);
      write_byte(8'h40, 1'b0, "nm_addr_nack");
      check("nm_state_ignore", dbg_state, ST_IGNORE);
      write_byte(8'h12, 1'b0, "nm_data_nack");
      i2c_stop();
      check("nm_pull_cycles", pull_cnt - p0, 0);
      check("nm_port_out", port_out, 8'hA5);
      check("nm_strobe_count", strobe_cnt - s0, 0);
      check("nm_busy_after_stop", busy, 0);

      // Read: port_in 3C returned twice, ACK then NACK.
      port_in = 8'h3C;
      i2c_start();
      write_byte(8'h4F, 1'b1, "rd_addr_ack");
      read_byte(rb, 1'b1);
      check("rd_byte0", rb, 8'h3C);
      read_byte(rb, 1'b0);
      check("rd_byte1", rb, 8'h3C);
      check("rd_release_after_nack", sda_pull, 0);
      check("rd_state_ignore", dbg_state, ST_IGNORE);
      i2c_stop();
      check("rd_busy_after_stop", busy, 0);
      check("rd_port_out", port_out, 8'hA5);

      // Multi-byte write, repeated START, then read.
      s0 = strobe_cnt;
      port_in = 8'hC3;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      i2c_start();
      write_byte(8'h4E, 1'b1, "mb_addr_ack");
      write_byte(8'h11, 1'b1, "mb_data0_ack");
      check("mb_port_out_0", port_out, 8'h11);
      write_byte(8'h22, 1'b1, "mb_data1_ack");
      check("mb_port_out_1", port_out, 8'h22);
      i2c_start();
      check("mb_busy_after_rstart", busy, 1);
      write_byte(8'h4F, 1'b1, "mb_raddr_ack");
      read_byte(rb, 1'b0);
      check("mb_read_byte", rb, 8'hC3);
      i2c_stop();
      check("mb_strobe_count", strobe_cnt - s0, 2);
      check("mb_port_out_final", port_out, 8'h22);

      // Abort mid-byte: partial data discarded.
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h4E, 1'b1, "ab_addr_ack");
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      check("ab_port_out", port_out, 8'h22);
      check("ab_state_idle", dbg_state, ST_IDLE);
      check("ab_busy", busy, 0);
      check("ab_strobe_count", strobe_cnt - s0, 0);

      // Full write after the abort.
      exp_q.push_back(8'h77);
      i2c_start();
      write_byte(8'h4E, 1'b1, "aw_addr_ack");
      write_byte(8'h77, 1'b1, "aw_data_ack");
      i2c_stop();
      check("aw_port_out", port_out, 8'h77);
      check("aw_strobe_count", strobe_cnt - s0, 1);

      // Reset while the target is driving the ACK.
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(8'h4E >> i);
      sda_m = 1'b1; wait_clk(8);
      scl_m = 1'b1; wait_clk(4);
      check("mr_pull_before", sda_pull, 1);
      nrst = 1'b0;
      #1;
      check("mr_pull", sda_pull, 0);
      check("mr_port_out", port_out, 8'h00);
      check("mr_busy", busy, 0);
      check("mr_strobe", wr_strobe, 0);
      check("mr_state", dbg_state, ST_IDLE);
      scl_m = 1'b1; sda_m = 1'b1;
      wait_clk(4);
      nrst = 1'b1;
      wait_clk(8);
      check("mr_state_after", dbg_state, ST_IDLE);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
